// File: rtl/z16_data_memory.sv
// -----------------------------------------------------------------------------
// z16_data_memory
//
// Word-addressed 16-bit data memory with one shared address port, an
// asynchronous (combinational) read path and a synchronous write.
//
// Ports
//   i_clk    in   1   clock; writes commit on its rising edge
//   i_rst_n  in   1   asynchronous active-low reset
//   i_addr   in  16   word address; only i_addr[ADDR_BITS-1:0] is decoded
//   i_wen    in   1   write enable, active-high
//   i_data   in  16   write data
//   o_data   out 16   read data, mem[i_addr[ADDR_BITS-1:0]], or 0 in reset
//
// Parameters
//   ADDR_BITS  number of decoded address bits; depth = 2**ADDR_BITS words
//
// Reset forces o_data to zero and blocks writes, but it never clears the
// array, so stored words survive a reset pulse.
// -----------------------------------------------------------------------------
module z16_data_memory #(
  parameter int ADDR_BITS = 12
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [15:0] i_addr,
  input  logic        i_wen,
  input  logic [15:0] i_data,
  output logic [15:0] o_data
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [15:0]          mem_q [DEPTH];
  logic [ADDR_BITS-1:0] word_addr;

  // Write-arm flag. It is cleared asynchronously by reset and only set by the
  // first rising edge that sees i_rst_n high. A write therefore needs the arm
  // flag as it stood *before* the edge, so an edge coincident with reset
  // release can never commit, whatever order the edge and release resolve in.
  logic wr_arm_q;
  logic wr_arm_d;
  logic wr_commit;

  assign word_addr = i_addr[ADDR_BITS-1:0];

  // Upper address bits alias; fold them into a sink so they are visibly
  // intentional rather than forgotten.
  generate
    if (ADDR_BITS < 16) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^i_addr[15:ADDR_BITS];
    end
  endgenerate

  always_comb begin
    wr_arm_d  = 1'b1;
    // Strict compare: an unknown enable must never be taken as a write.
    wr_commit = i_rst_n & wr_arm_q & (i_wen === 1'b1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_arm_q <= 1'b0;
    end else begin
      wr_arm_q <= wr_arm_d;
    end
  end

  // Storage has no reset on purpose: contents must persist across reset.
  always_ff @(posedge i_clk) begin
    if (wr_commit) begin
      mem_q[word_addr] <= i_data;
    end
  end

  // Combinational read; no write-first bypass, so a same-address write shows
  // the old word until the edge and the new word right after it.
  always_comb begin
    o_data = 16'h0000;
    if (i_rst_n) begin
      o_data = mem_q[word_addr];
    end
  end

endmodule

// File: tb/tb_z16_data_memory.sv
// -----------------------------------------------------------------------------
// tb_z16_data_memory
//
// Directed bench for z16_data_memory (ADDR_BITS = 12). Expected read values
// are pushed to a scoreboard queue when the stimulus is driven and popped and
// compared when o_data is sampled.
// -----------------------------------------------------------------------------
module tb_z16_data_memory;

  logic        clk;
  logic        rst_n;
  logic [15:0] addr;
  logic        wen;
  logic [15:0] wdata;
  logic [15:0] rdata;

  logic [15:0] sb_q [$];
  int          n_total;
  int          n_pass;

  z16_data_memory #(.ADDR_BITS(12)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_addr  (addr),
    .i_wen   (wen),
    .i_data  (wdata),
    .o_data  (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  task automatic expect_val(input logic [15:0] v);
    sb_q.push_back(v);
  endtask

  task automatic check(input string tag);
    logic [15:0] exp_v;
    n_total++;
    if (sb_q.size() == 0) begin
      $error("FAIL %s: scoreboard empty, observed=%h", tag, rdata);
    end else begin
      exp_v = sb_q.pop_front();
      assert (rdata === exp_v) n_pass++;
      else $error("FAIL %s: observed=%h expected=%h", tag, rdata, exp_v);
      $display("check %-14s addr=%h observed=%h expected=%h", tag, addr, rdata, exp_v);
    end
  endtask

  // One write: drive on the falling edge, commit on the next rising edge.
  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    addr  = a;
    wdata = d;
    wen   = 1'b1;
    @(posedge clk);
    #1;
    wen   = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst_n   = 1'b0;
    addr    = 16'h0000;
    wen     = 1'b0;
    wdata   = 16'h0000;

    // Reset state
    #1;
    expect_val(16'h0000); check("reset_out");

    // Release mid-cycle, then one idle edge to arm writes
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic write/read and aliasing
    wr(16'h8FFF, 16'h5555);
    addr = 16'h8FFF; #1;
    expect_val(16'h5555); check("basic_rd");
    addr = 16'h0FFF; #1;
    expect_val(16'h5555); check("alias_0fff");
    addr = 16'hFFFF; #1;
    expect_val(16'h5555); check("alias_ffff");

    // Write-enable gating across several edges
    wr(16'h0001, 16'h1234);
    @(negedge clk); addr = 16'h0001; wdata = 16'hAAAA; wen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      expect_val(16'h1234); check("wen_gate");
    end

    // Read during write: old before edge, new after
    wr(16'h0020, 16'h0001);
    @(negedge clk); addr = 16'h0020; wdata = 16'h0002; wen = 1'b1; #1;
    expect_val(16'h0001); check("rdw_before");
    @(posedge clk); #1;
    expect_val(16'h0002); check("rdw_after");
    wen = 1'b0;

    // Back-to-back writes, last write wins
    @(negedge clk); addr = 16'h0100; wdata = 16'h0A0A; wen = 1'b1;
    @(negedge clk); addr = 16'h0101; wdata = 16'h0B0B;
    @(negedge clk); addr = 16'h0100; wdata = 16'h0C0C;
    @(negedge clk); wen = 1'b0; addr = 16'h0100; #1;
    expect_val(16'h0C0C); check("b2b_last");
    addr = 16'h0101; #1;
    expect_val(16'h0B0B); check("b2b_other");

    // Reset behaviour: in-flight write aborted, writes blocked, data kept
    wr(16'h0010, 16'hBEEF);
    @(negedge clk); addr = 16'h0010; wdata = 16'h0000; wen = 1'b1;
    #2; rst_n = 1'b0; #1;
    expect_val(16'h0000); check("rst_async");
    @(posedge clk); #1;
    @(posedge clk); #1;
    expect_val(16'h0000); check("rst_hold");
    @(negedge clk); wen = 1'b0; rst_n = 1'b1; #1;
    expect_val(16'hBEEF); check("rst_keep");

    // Release coincident with a rising edge must not write on that edge
    @(posedge clk); #1;
    wr(16'h0030, 16'h2222);
    @(negedge clk); rst_n = 1'b0; addr = 16'h0030; wdata = 16'h1111; wen = 1'b1;
    @(posedge clk); rst_n = 1'b1; #1;
    expect_val(16'h2222); check("rel_edge");
    @(posedge clk); #1;
    expect_val(16'h1111); check("rel_next");
    wen = 1'b0;

    // Sweep: write addr^A5A5 everywhere, read back through aliased addresses
    for (int i = 0; i < 4096; i++) begin
      wr(16'(i), 16'(i) ^ 16'hA5A5);
    end
    for (int i = 0; i < 4096; i++) begin
      expect_val(16'(i) ^ 16'hA5A5);
      addr = 16'(i) | (16'(i & 15) << 12);
      #1;
      n_total++;
      begin
        logic [15:0] e;
        e = sb_q.pop_front();
        assert (rdata === e) n_pass++;
        else $error("FAIL sweep: addr=%h observed=%h expected=%h", addr, rdata, e);
      end
    end
    $display("sweep done: 4096 words read back");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/z16_data_memory.md
Z16_DATA_MEMORY -- requirements
Module: z16_data_memory

Interface
REQ-001 Parameter: ADDR_BITS, default 12, number of low address bits decoded; depth = 2**ADDR_BITS 16-bit words (4096 words at default).
REQ-002 The block SHALL have one clock. Reset SHALL be asynchronous and active-low.
REQ-003 i_clk    input   1   clock; all writes occur on its rising edge.
REQ-004 i_rst_n  input   1   asynchronous active-low reset.
REQ-005 i_addr   input   16  word address; only i_addr[ADDR_BITS-1:0] is decoded.
REQ-006 i_wen    input   1   write enable, active-high, sampled at rising i_clk.
REQ-007 i_data   input   16  write data.
REQ-008 o_data   output  16  read data.

Function
REQ-009 Storage SHALL be an array of 2**ADDR_BITS words of 16 bits, word-addressed; there are no byte lanes and no byte enables.
REQ-010 Address decode SHALL use i_addr[ADDR_BITS-1:0] only; upper bits SHALL be ignored, so addresses alias modulo depth (at default, 0x8FFF and 0x0FFF select word 0xFFF).
REQ-011 Write: at rising i_clk with i_rst_n=1 and i_wen=1, mem[i_addr[ADDR_BITS-1:0]] SHALL take i_data; all other words SHALL be unchanged.
REQ-012 With i_wen=0, no word SHALL change at the clock edge.
REQ-013 Read SHALL be combinational: o_data = mem[i_addr[ADDR_BITS-1:0]], with zero cycles of latency from an i_addr change.
REQ-014 Read is independent of i_wen; read and write SHALL share a single address port.
REQ-015 Same-address read during a write: o_data SHALL show the old word until the rising edge, then the new word in the same cycle after the edge (no write-first bypass).
REQ-016 Back-to-back writes on consecutive cycles SHALL each commit; if the same address is written twice, the last write wins.
REQ-017 There is no handshake, ready or valid signalling; every access SHALL complete in one cycle.
REQ-018 X or Z on i_wen SHALL NOT be treated as a write; the implementation SHALL require i_wen===1 to commit.

Reset
REQ-019 While i_rst_n=0, o_data SHALL be forced to 16'h0000, asynchronously with respect to i_clk.
REQ-020 While i_rst_n=0, writes SHALL be suppressed regardless of i_wen.
REQ-021 Reset SHALL NOT clear array contents; after reset release, previously written words SHALL read back unchanged.
REQ-022 The array power-up content is undefined; the bench SHALL NOT rely on it.
REQ-023 Reset deassertion coincident with a rising edge with i_wen=1: that edge SHALL NOT write; the first write is the next rising edge with i_rst_n=1.
REQ-024 Asserting reset during a write cycle, before the edge, SHALL abort that write.

Verification
REQ-025 Basic write/read: with i_rst_n=1, write 0x5555 to 0x8FFF, then set i_wen=0 and i_addr=0x8FFF -> o_data=0x5555 immediately after the edge.
REQ-026 Alias: after scenario 1, set i_addr=0x0FFF (ADDR_BITS=12) -> o_data=0x5555 combinationally, with no clock needed.
REQ-027 Write-enable gating: hold i_wen=0 with i_data=0xAAAA at 0x0001 across several edges -> o_data at 0x0001 keeps its prior value (for example 0x1234).
REQ-028 Reset behaviour: write 0xBEEF to 0x0010, then assert i_rst_n=0 mid-cycle -> o_data=0x0000 immediately. Pulse i_wen=1 with 0x0000 at 0x0010 during reset, then release -> o_data=0xBEEF.
REQ-029 Read-during-write: write 0x0002 at 0x0020 holding 0x0001 -> o_data=0x0001 before the edge and 0x0002 after it.
REQ-030 Sweep: write addr^0xA5A5 to every word, then read all -> each word matches and no aliasing errors occur within depth.
